// File: rtl/universal_dreg_pkg.sv
// Shared types for the universal_dreg register bank: the operation-select encoding.
package universal_dreg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_INV  = 3'd6,
    MODE_CLR  = 3'd7
  } mode_t;

endpackage

// File: rtl/universal_dreg_next.sv
// Combinational next-state selector for universal_dreg; enable and reset are applied by the caller.
module universal_dreg_next
  import universal_dreg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] q_i,
  input  mode_t            mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             serial_in_l_i,
  input  logic             serial_in_r_i,
  output logic [WIDTH-1:0] q_next_o
);

  // Serial and parallel inputs only reach the result in their own mode.
  always_comb begin
    q_next_o = q_i;
    case (mode_i)
      MODE_HOLD: q_next_o = q_i;
      MODE_LOAD: q_next_o = data_i;
      MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], serial_in_r_i};
      MODE_SHR:  q_next_o = {serial_in_l_i, q_i[WIDTH-1:1]};
      MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_INV:  q_next_o = ~q_i;
      MODE_CLR:  q_next_o = RESET_VALUE;
    endcase
  end

endmodule

// File: rtl/universal_dreg.sv
// WIDTH-bit mode-selected register with serial ends, complement output and a change-indicator pulse.
module universal_dreg
  import universal_dreg_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             input_clock,
  input  logic             input_reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic             busy_pulse
);

  // Declaration initialisers give the power-up state without a reset edge.
  logic [WIDTH-1:0] q_q = RESET_VALUE;
  logic             busy_q = 1'b0;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_d;
  logic             busy_d;

  universal_dreg_next #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_next (
    .q_i           (q_q),
    .mode_i        (mode_t'(mode)),
    .data_i        (data_in),
    .serial_in_l_i (serial_in_l),
    .serial_in_r_i (serial_in_r),
    .q_next_o      (q_next)
  );

  always_comb begin
    q_d    = q_q;
    busy_d = 1'b0;
    if (enable) begin
      q_d    = q_next;
      busy_d = (q_next != q_q);
    end
  end

  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      q_q    <= RESET_VALUE;
      busy_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      busy_q <= busy_d;
    end
  end

  assign q            = q_q;
  assign q_n          = ~q_q;
  assign serial_out_l = q_q[WIDTH-1];
  assign serial_out_r = q_q[0];
  assign busy_pulse   = busy_q;

endmodule

// File: tb/tb_universal_dreg.sv
// Bench for universal_dreg: directed walk through each mode, then random traffic against an arithmetic model.
module tb_universal_dreg;

  localparam int unsigned W  = 4;
  localparam logic [W-1:0] RV = 4'b1010;

  logic         input_clock = 1'b0;
  logic         input_reset;
  logic         enable;
  logic [2:0]   mode;
  logic [W-1:0] data_in;
  logic         serial_in_l;
  logic         serial_in_r;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic         serial_out_l;
  logic         serial_out_r;
  logic         busy_pulse;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q    = RV;
  logic         exp_busy = 1'b0;

  universal_dreg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .input_clock  (input_clock),
    .input_reset  (input_reset),
    .enable       (enable),
    .mode         (mode),
    .data_in      (data_in),
    .serial_in_l  (serial_in_l),
    .serial_in_r  (serial_in_r),
    .q            (q),
    .q_n          (q_n),
    .serial_out_l (serial_out_l),
    .serial_out_r (serial_out_r),
    .busy_pulse   (busy_pulse)
  );

  always #5 input_clock = ~input_clock;

  // Reference next state using integer arithmetic on a 4-bit word (value 0..15).
  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input int m,
                                              input logic [W-1:0] d, input logic sl,
                                              input logic sr);
    int c;
    int r;
    c = int'(cur);
    case (m)
      0:       r = c;
      1:       r = int'(d);
      2:       r = (c * 2 + int'(sr)) % 16;
      3:       r = c / 2 + int'(sl) * 8;
      4:       r = (c * 2) % 16 + c / 8;
      5:       r = c / 2 + (c % 2) * 8;
      6:       r = 15 - c;
      default: r = int'(RV);
    endcase
    return r[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q"},    q,                    exp_q);
    check({tag, "_qn"},   q_n,                  exp_q ^ 4'hF);
    check({tag, "_sol"},  {3'b0, serial_out_l}, {3'b0, exp_q[W-1]});
    check({tag, "_sor"},  {3'b0, serial_out_r}, {3'b0, exp_q[0]});
    check({tag, "_busy"}, {3'b0, busy_pulse},   {3'b0, exp_busy});
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic en, input int m,
                      input logic [W-1:0] d, input logic sl, input logic sr);
    logic [W-1:0] nq;
    input_reset = rst;
    enable      = en;
    mode        = m[2:0];
    data_in     = d;
    serial_in_l = sl;
    serial_in_r = sr;
    if (rst) begin
      nq       = RV;
      exp_busy = 1'b0;
    end else if (en) begin
      nq       = model_next(exp_q, m, d, sl, sr);
      exp_busy = (nq != exp_q);
    end else begin
      nq       = exp_q;
      exp_busy = 1'b0;
    end
    exp_q = nq;
    @(posedge input_clock);
    #1;
    check_all(tag);
  endtask

  initial begin
    input_reset = 1'b0;
    enable      = 1'b0;
    mode        = 3'd0;
    data_in     = '0;
    serial_in_l = 1'b0;
    serial_in_r = 1'b0;
    #1;
    check_all("powerup");

    step("tp1_rst",  1, 0, 0, 4'b0000, 0, 0);
    check("tp1_rst_abs", q, 4'b1010);
    step("tp1_load", 0, 1, 1, 4'b0011, 0, 0);
    check("tp1_load_abs", q, 4'b0011);
    check("tp1_busy_abs", {3'b0, busy_pulse}, 4'b0001);
    step("tp2_shl",  0, 1, 2, 4'b1111, 1, 1);
    check("tp2_shl_abs", q, 4'b0111);
    step("tp2_shr",  0, 1, 3, 4'b0000, 1, 0);
    check("tp2_shr_abs", q, 4'b1011);
    step("tp3_ld8",  0, 1, 1, 4'b1000, 0, 0);
    step("tp3_rol",  0, 1, 4, 4'b0000, 1, 1);
    check("tp3_rol_abs", q, 4'b0001);
    step("tp3_ror",  0, 1, 5, 4'b0000, 1, 1);
    check("tp3_ror_abs", q, 4'b1000);
    step("tp3_ldf",  0, 1, 1, 4'b1111, 0, 0);
    step("tp3_rolf", 0, 1, 4, 4'b0000, 0, 0);
    check("tp3_rolf_busy", {3'b0, busy_pulse}, 4'b0000);
    step("tp3_rorf", 0, 1, 5, 4'b0000, 0, 0);
    step("tp4_ld6",  0, 1, 1, 4'b0110, 0, 0);
    step("tp4_inv",  0, 1, 6, 4'b0000, 0, 0);
    check("tp4_inv_abs", q, 4'b1001);
    step("tp4_clr",  0, 1, 7, 4'b0000, 0, 0);
    check("tp4_clr_abs", q, 4'b1010);
    for (int i = 0; i < 3; i++) step("tp5_dis", 0, 0, 6, 4'b0101, 1, 1);
    step("tp5_redld", 0, 1, 1, 4'b1010, 0, 0);
    check("tp5_redld_busy", {3'b0, busy_pulse}, 4'b0000);
    step("tp6_ld0",   0, 1, 1, 4'b0000, 0, 0);
    step("tp6_rstld", 1, 1, 1, 4'b1111, 0, 0);
    check("tp6_rstld_abs", q, 4'b1010);
    step("tp6_shl",   0, 1, 2, 4'b0000, 1, 0);
    check("tp6_shl_abs", q, 4'b0100);

    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 7)),
           W'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
